rwg_weight_loader: RTL and testbench

Sequencer directly downstream of the rwg LFSR random weight generator. It drives rwg's twelve active-low seed-select inputs one neuron at a time and captures the resulting 11-bit LFSR words into a local buffer. It then converts each word to a signed two's-complement weight and streams it, with a valid/ready handshake and a flat address, into the ELM hidden-layer weight memory.

---
 rtl/rwg_weight_loader.sv | 157 +++++++++++++++
 tb/tb_rwg_weight_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rwg_weight_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rwg_weight_loader: seeds rwg one neuron at a time, buffers the LFSR words
// and streams them as signed weights into the hidden-layer weight memory.
// Revision: 1.0
// ---------------------------------------------------------------------------
module rwg_weight_loader #(
  parameter int NUM_NEURONS = 12,
  parameter int WPN         = 11,
  parameter int W           = 11,
  parameter int ADDR_W      = 8
) (
  input  logic              clk2,
  input  logic              rst_n,
  input  logic              start,
  input  logic [W-1:0]      lfsr_random,
  output logic [11:0]       seed_n,
  output logic              busy,
  output logic              done,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [W-1:0]      w_data,
  output logic [ADDR_W-1:0] w_addr,
  output logic [3:0]        neuron_idx
);

  localparam int                IDX_W       = (WPN > 1) ? $clog2(WPN) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(WPN - 1);
  localparam logic [3:0]        LAST_NEURON = 4'(NUM_NEURONS - 1);
  localparam logic [ADDR_W-1:0] WPN_A       = ADDR_W'(WPN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEED    = 3'd1,
    S_CAPTURE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          neuron_q, neuron_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    rd_q, rd_d;
  logic [11:0]         seed_n_q, seed_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                w_valid_q, w_valid_d;
  logic [W-1:0]        w_data_q, w_data_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [W-1:0]        rd_word;
  logic [W-1:0]        wbuf_q [WPN];

  // Offset-binary LFSR sample to two's complement: flip the MSB.
  function automatic logic [W-1:0] to_weight(input logic [W-1:0] s);
    return {~s[W-1], s[W-2:0]};
  endfunction

  always_comb begin
    state_d  = state_q;
    neuron_d = neuron_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    w_data_d = w_data_q;
    w_addr_d = w_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SEED;
          neuron_d = 4'd0;
        end
      end
      S_SEED: begin
        state_d = S_CAPTURE;
        cnt_d   = '0;
      end
      S_CAPTURE: begin
        if (cnt_q == LAST_IDX) begin
          state_d = S_DRAIN;
          rd_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_valid_q && w_ready) begin
          if (rd_q == LAST_IDX) begin
            if (neuron_q == LAST_NEURON) begin
              state_d = S_DONE;
            end else begin
              neuron_d = neuron_q + 4'd1;
              state_d  = S_SEED;
            end
          end else begin
            rd_d = rd_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The final capture lands in the buffer on the same edge the first word is
    // registered, so forward the live sample when it is the one being read.
    if (state_q == S_CAPTURE && rd_d == cnt_q) rd_word = lfsr_random;
    else                                       rd_word = wbuf_q[rd_d];

    if (state_d == S_DRAIN) begin
      w_data_d = to_weight(rd_word);
      w_addr_d = ADDR_W'(neuron_d) * WPN_A + ADDR_W'(rd_d);
    end

    seed_n_d  = (state_d == S_SEED) ? ~(12'd1 << neuron_d) : 12'hFFF;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    w_valid_d = (state_d == S_DRAIN);
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      neuron_q  <= 4'd0;
      cnt_q     <= '0;
      rd_q      <= '0;
      seed_n_q  <= 12'hFFF;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      w_addr_q  <= '0;
    end else begin
      state_q   <= state_d;
      neuron_q  <= neuron_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      seed_n_q  <= seed_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      w_valid_q <= w_valid_d;
      w_data_q  <= w_data_d;
      w_addr_q  <= w_addr_d;
    end
  end

  always_ff @(posedge clk2) begin
    if (state_q == S_CAPTURE) wbuf_q[cnt_q] <= lfsr_random;
  end

  assign seed_n     = seed_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign w_valid    = w_valid_q;
  assign w_data     = w_data_q;
  assign w_addr     = w_addr_q;
  assign neuron_idx = neuron_q;

endmodule
`default_nettype wire

// File: tb/tb_rwg_weight_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rwg_weight_loader: directed bench with an rwg LFSR model per instance.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_rwg_weight_loader;

  logic        clk2 = 1'b0;
  logic        rst_n, start, w_ready;
  logic [10:0] lfsr_random = '0;
  logic [11:0] seed_n;
  logic        busy, done, w_valid;
  logic [10:0] w_data;
  logic [7:0]  w_addr;
  logic [3:0]  neuron_idx;

  logic        start_s, w_ready_s;
  logic [10:0] lfsr_s = '0;
  logic [11:0] seed_n_s;
  logic        busy_s, done_s, w_valid_s;
  logic [10:0] w_data_s;
  logic [7:0]  w_addr_s;
  logic [3:0]  neuron_idx_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk2 = ~clk2;

  rwg_weight_loader dut (
    .clk2(clk2), .rst_n(rst_n), .start(start), .lfsr_random(lfsr_random),
    .seed_n(seed_n), .busy(busy), .done(done), .w_valid(w_valid),
    .w_ready(w_ready), .w_data(w_data), .w_addr(w_addr), .neuron_idx(neuron_idx)
  );

  rwg_weight_loader #(.NUM_NEURONS(1), .WPN(4)) dut_s (
    .clk2(clk2), .rst_n(rst_n), .start(start_s), .lfsr_random(lfsr_s),
    .seed_n(seed_n_s), .busy(busy_s), .done(done_s), .w_valid(w_valid_s),
    .w_ready(w_ready_s), .w_data(w_data_s), .w_addr(w_addr_s), .neuron_idx(neuron_idx_s)
  );

  function automatic logic [10:0] lfsr_step(input logic [10:0] s);
    return {s[10] ^ s[8], s[10:1]};
  endfunction

  function automatic logic [10:0] seed_val(input int k);
    case (k)
      0: return 11'b01011010110;
      1: return 11'b10100101001;
      2: return 11'h3A5;
      3: return 11'h1C7;
      4: return 11'h64B;
      5: return 11'h0F3;
      6: return 11'h58E;
      7: return 11'h2B1;
      8: return 11'h7D4;
      9: return 11'h13F;
      10: return 11'h4A2;
      default: return 11'h69D;
    endcase
  endfunction

  function automatic logic [10:0] seed_from(input logic [11:0] sn);
    for (int k = 0; k < 12; k++) if (!sn[k]) return seed_val(k);
    return 11'h000;
  endfunction

  function automatic logic [10:0] exp_word(input int n, input int j);
    logic [10:0] s;
    s = seed_val(n);
    for (int i = 0; i < j; i++) s = lfsr_step(s);
    return {~s[10], s[9:0]};
  endfunction

  // rwg model: reloads while a seed select is low, otherwise shifts right.
  always @(posedge clk2) begin
    lfsr_random <= (seed_n   != 12'hFFF) ? seed_from(seed_n)   : lfsr_step(lfsr_random);
    lfsr_s      <= (seed_n_s != 12'hFFF) ? seed_from(seed_n_s) : lfsr_step(lfsr_s);
  end

  logic [10:0] got_data [$];
  logic [7:0]  got_addr [$];
  logic [11:0] seed_log [$];
  int          strobe_xfers [$];
  int          seed_long, bad_seed, done_pulses, busy_late, stall_seen, frozen_bad;
  logic        busy_after_done;
  bit          timed_out;

  task automatic run_load(input int stall_n, input int stall_rd, input int stall_len, input bit poke);
    int          done_cyc, stall_left;
    logic        prev_low, rdy;
    logic [10:0] fz_d;
    logic [7:0]  fz_a;
    got_data.delete(); got_addr.delete(); seed_log.delete(); strobe_xfers.delete();
    seed_long = 0; bad_seed = 0; done_pulses = 0; busy_late = 0;
    stall_seen = 0; frozen_bad = 0; busy_after_done = 1'bx; timed_out = 0;
    done_cyc = -1; stall_left = stall_len; prev_low = 0; fz_d = '0; fz_a = '0;
    @(negedge clk2);
    start = 1'b1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk2);
      start = 1'b0;
      if (seed_n != 12'hFFF) begin
        if (prev_low) seed_long++;
        seed_log.push_back(seed_n);
        strobe_xfers.push_back(got_data.size());
      end
      prev_low = (seed_n != 12'hFFF);
      if ($countones(~seed_n) > 1) bad_seed++;
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after_done = busy;
      if (done_cyc >= 0 && cyc > done_cyc + 1 && busy) busy_late++;
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
        if (poke) start = 1'b1;
      end
      if (poke && (cyc == 5 || cyc == 18 || cyc == 100)) start = 1'b1;
      rdy = 1'b1;
      if (w_valid && stall_left > 0 && neuron_idx == 4'(stall_n) &&
          w_addr == 8'(stall_n * 11 + stall_rd)) begin
        if (stall_left == stall_len) begin
          fz_d = w_data; fz_a = w_addr;
        end else if (w_data !== fz_d || w_addr !== fz_a) begin
          frozen_bad++;
        end
        stall_seen++; stall_left--; rdy = 1'b0;
      end
      w_ready = rdy;
      if (w_valid && rdy) begin
        got_data.push_back(w_data);
        got_addr.push_back(w_addr);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
    end
    if (done_cyc < 0) timed_out = 1;
    start = 1'b0;
    w_ready = 1'b1;
  endtask

  task automatic test_reset();
    n_checks++; if (seed_n !== 12'hFFF) begin n_fail++; $display("FAIL reset_seed_n: got %h want fff", seed_n); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL reset_w_valid: got %b want 0", w_valid); end
    n_checks++; if (w_data !== 11'h000) begin n_fail++; $display("FAIL reset_w_data: got %h want 000", w_data); end
    n_checks++; if (w_addr !== 8'h00) begin n_fail++; $display("FAIL reset_w_addr: got %0d want 0", w_addr); end
    n_checks++; if (neuron_idx !== 4'd0) begin n_fail++; $display("FAIL reset_neuron_idx: got %0d want 0", neuron_idx); end
  endtask

  task automatic test_nominal();
    run_load(-1, 0, 0, 1'b0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL nom_timeout: got timeout want done"); end
    n_checks++; if (seed_log.size() != 12) begin n_fail++; $display("FAIL nom_strobes: got %0d want 12", seed_log.size()); end
    n_checks++; if (seed_log.size() < 1 || seed_log[0] !== 12'hFFE) begin n_fail++; $display("FAIL nom_first_seed: got %h want ffe", seed_log.size() ? seed_log[0] : 12'h0); end
    n_checks++; if (seed_long != 0 || bad_seed != 0) begin n_fail++; $display("FAIL nom_seed_shape: got long=%0d multi=%0d want 0 0", seed_long, bad_seed); end
    n_checks++; if (got_data.size() != 132) begin n_fail++; $display("FAIL nom_count: got %0d want 132", got_data.size()); end
    if (got_data.size() == 132) begin
      n_checks++; if (got_addr[0] !== 8'd0 || got_data[0] !== 11'(-298)) begin n_fail++; $display("FAIL nom_word0: got addr %0d data %0d want 0 -298", got_addr[0], $signed(got_data[0])); end
      n_checks++; if (got_addr[1] !== 8'd1 || got_data[1] !== 11'(-661)) begin n_fail++; $display("FAIL nom_word1: got addr %0d data %0d want 1 -661", got_addr[1], $signed(got_data[1])); end
      n_checks++; if (got_addr[11] !== 8'd11 || got_data[11] !== 11'(297)) begin n_fail++; $display("FAIL nom_word11: got addr %0d data %0d want 11 297", got_addr[11], $signed(got_data[11])); end
      n_checks++; if (got_addr[131] !== 8'd131) begin n_fail++; $display("FAIL nom_last_addr: got %0d want 131", got_addr[131]); end
      for (int i = 0; i < 132; i++) begin
        n_checks++;
        if (got_addr[i] !== 8'(i) || got_data[i] !== exp_word(i / 11, i % 11)) begin
          n_fail++; $display("FAIL nom_seq[%0d]: got %0d/%h want %0d/%h", i, got_addr[i], got_data[i], i, exp_word(i / 11, i % 11));
        end
      end
    end
    n_checks++; if (seed_log.size() < 2 || seed_log[1] !== 12'hFFD || strobe_xfers[1] != 11) begin n_fail++; $display("FAIL nom_neuron1_seed: got %h after %0d xfers want ffd after 11", seed_log.size() > 1 ? seed_log[1] : 12'h0, strobe_xfers.size() > 1 ? strobe_xfers[1] : -1); end
    n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL nom_done_pulses: got %0d want 1", done_pulses); end
    n_checks++; if (busy_after_done !== 1'b0 || busy_late != 0) begin n_fail++; $display("FAIL nom_busy_fall: got %b late=%0d want 0 0", busy_after_done, busy_late); end
  endtask

  task automatic test_backpressure();
    run_load(2, 3, 5, 1'b0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout: got timeout want done"); end
    n_checks++; if (stall_seen != 5) begin n_fail++; $display("FAIL bp_valid_held: got %0d stalled cycles want 5", stall_seen); end
    n_checks++; if (frozen_bad != 0) begin n_fail++; $display("FAIL bp_frozen: got %0d changes want 0", frozen_bad); end
    n_checks++; if (got_data.size() != 132) begin n_fail++; $display("FAIL bp_count: got %0d want 132", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 132; i++) begin
      n_checks++;
      if (got_addr[i] !== 8'(i) || got_data[i] !== exp_word(i / 11, i % 11)) begin
        n_fail++; $display("FAIL bp_seq[%0d]: got %0d/%h want %0d/%h", i, got_addr[i], got_data[i], i, exp_word(i / 11, i % 11));
      end
    end
  endtask

  task automatic test_start_ignored();
    run_load(-1, 0, 0, 1'b1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL si_timeout: got timeout want done"); end
    n_checks++; if (seed_log.size() != 12) begin n_fail++; $display("FAIL si_strobes: got %0d want 12", seed_log.size()); end
    n_checks++; if (got_data.size() != 132) begin n_fail++; $display("FAIL si_count: got %0d want 132", got_data.size()); end
    n_checks++; if (done_pulses != 1 || busy_late != 0) begin n_fail++; $display("FAIL si_after_done: got done=%0d late_busy=%0d want 1 0", done_pulses, busy_late); end
    for (int i = 0; i < got_data.size() && i < 132; i++) begin
      n_checks++;
      if (got_addr[i] !== 8'(i) || got_data[i] !== exp_word(i / 11, i % 11)) begin
        n_fail++; $display("FAIL si_seq[%0d]: got %0d/%h want %0d/%h", i, got_addr[i], got_data[i], i, exp_word(i / 11, i % 11));
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    bit hit;
    hit = 0;
    @(negedge clk2);
    start = 1'b1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk2);
      start = 1'b0;
      w_ready = 1'b1;
      if (w_valid && neuron_idx == 4'd4 && w_addr == 8'd50) begin hit = 1; break; end
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL rst_reach_n4_rd6: got not reached want reached"); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (seed_n !== 12'hFFF || w_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_async: got seed_n=%h valid=%b busy=%b want fff 0 0", seed_n, w_valid, busy); end
    n_checks++; if (neuron_idx !== 4'd0 || w_addr !== 8'd0) begin n_fail++; $display("FAIL rst_async_idx: got n=%0d addr=%0d want 0 0", neuron_idx, w_addr); end
    repeat (3) @(negedge clk2);
    rst_n = 1'b1;
    run_load(-1, 0, 0, 1'b0);
    n_checks++; if (got_data.size() != 132 || timed_out) begin n_fail++; $display("FAIL rst_reload_count: got %0d want 132", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 132; i++) begin
      n_checks++;
      if (got_addr[i] !== 8'(i) || got_data[i] !== exp_word(i / 11, i % 11)) begin
        n_fail++; $display("FAIL rst_seq[%0d]: got %0d/%h want %0d/%h", i, got_addr[i], got_data[i], i, exp_word(i / 11, i % 11));
      end
    end
  endtask

  task automatic test_small_config();
    logic [10:0] d [$];
    logic [7:0]  a [$];
    int          dn;
    bit          hi_seed, fin;
    dn = 0; hi_seed = 0; fin = 0;
    w_ready_s = 1'b1;
    @(negedge clk2);
    start_s = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk2);
      start_s = 1'b0;
      if (seed_n_s[11:1] != 11'h7FF) hi_seed = 1;
      if (w_valid_s) begin d.push_back(w_data_s); a.push_back(w_addr_s); end
      if (done_s) dn++;
      if (dn > 0 && !busy_s) begin fin = 1; break; end
    end
    n_checks++; if (!fin) begin n_fail++; $display("FAIL small_timeout: got timeout want done"); end
    n_checks++; if (d.size() != 4) begin n_fail++; $display("FAIL small_count: got %0d want 4", d.size()); end
    for (int i = 0; i < d.size() && i < 4; i++) begin
      n_checks++;
      if (a[i] !== 8'(i) || d[i] !== exp_word(0, i)) begin
        n_fail++; $display("FAIL small_seq[%0d]: got %0d/%h want %0d/%h", i, a[i], d[i], i, exp_word(0, i));
      end
    end
    n_checks++; if (dn != 1) begin n_fail++; $display("FAIL small_done: got %0d want 1", dn); end
    n_checks++; if (hi_seed) begin n_fail++; $display("FAIL small_high_seed: got asserted want never"); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; w_ready = 1'b1; start_s = 1'b0; w_ready_s = 1'b1;
    #12;
    test_reset();
    @(negedge clk2);
    rst_n = 1'b1;
    test_nominal();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_drain();
    test_small_config();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
